// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-type codes, FSM state
// encoding and the transfer timeout limit.
package lsu_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b011;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  localparam logic [1:0] STORE_SB = 2'b00;
  localparam logic [1:0] STORE_SH = 2'b01;
  localparam logic [1:0] STORE_SW = 2'b10;

  // Cycles a transfer may spend in REQ/WAIT_R before it is abandoned.
  localparam logic [7:0] TIMEOUT = 8'd255;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: access legality/alignment, byte enables, store
// data replication and load-result extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  load,
  input  logic [1:0]  store,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [2:0]  ext_load,
  input  logic [1:0]  ext_lane,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic        load_ok;
  logic        store_ok;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    load_ok = 1'b0;
    case (load)
      LOAD_LB, LOAD_LBU: load_ok = 1'b1;
      LOAD_LH, LOAD_LHU: load_ok = ~addr_lo[0];
      LOAD_LW:           load_ok = (addr_lo == 2'b00);
      default:           load_ok = 1'b0;
    endcase

    store_ok  = 1'b0;
    be        = 4'b0000;
    wdata_rep = wdata;
    case (store)
      STORE_SB: begin
        store_ok  = 1'b1;
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      STORE_SH: begin
        store_ok  = ~addr_lo[0];
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      STORE_SW: begin
        store_ok  = (addr_lo == 2'b00);
        be        = 4'b1111;
      end
      default: ;
    endcase

    // Simultaneous read and write is treated as an illegal access.
    legal = (read & ~write & load_ok) | (write & ~read & store_ok);
  end

  always_comb begin
    byte_sel  = rdata[{ext_lane, 3'b000} +: 8];
    half_sel  = ext_lane[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = rdata;
    case (ext_load)
      LOAD_LB:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: rdata_ext = {24'h000000, byte_sel};
      LOAD_LH:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: rdata_ext = {16'h0000, half_sel};
      default:  rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Load/store unit controller: accepts one access from execute, stalls the
// pipeline while it runs a single request/response transfer on the dmem port.
module lsu_controller
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Load,
  input  logic [1:0]  Store,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Stall,
  output logic        Done,
  output logic [31:0] RData,
  output logic        MisalignFault,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  fsm_state
);

  // Handshake: a request is held (dmem_req plus stable addr/be/wdata/we)
  // until the cycle dmem_ready=1; read data is taken in the first cycle with
  // dmem_rvalid=1, which may coincide with the dmem_ready cycle.

  lsu_state_t  state;
  lsu_state_t  next_state;

  logic [31:0] addr_q;
  logic        is_load_q;
  logic [2:0]  load_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [7:0]  timer_q;

  logic        legal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_ext;

  logic        accept;
  logic        load_cpl;
  logic        timed_out;
  logic        stall_c;
  logic        fault_c;
  logic        req_c;
  logic        we_c;
  logic        done_c;

  lsu_align u_align (
    .read      (MemRead),
    .write     (MemWrite),
    .load      (Load),
    .store     (Store),
    .addr_lo   (Addr[1:0]),
    .wdata     (WData),
    .legal     (legal),
    .be        (be_c),
    .wdata_rep (wdata_c),
    .ext_load  (load_q),
    .ext_lane  (addr_q[1:0]),
    .rdata     (dmem_rdata),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    load_cpl   = 1'b0;
    stall_c    = 1'b0;
    fault_c    = 1'b0;
    req_c      = 1'b0;
    we_c       = 1'b0;
    done_c     = 1'b0;
    timed_out  = (timer_q == TIMEOUT);

    case (state)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          if (legal) begin
            accept     = 1'b1;
            stall_c    = 1'b1;
            next_state = S_REQ;
          end else begin
            fault_c = 1'b1;
          end
        end
      end

      S_REQ: begin
        req_c   = 1'b1;
        we_c    = ~is_load_q;
        stall_c = 1'b1;
        if (dmem_ready) begin
          if (!is_load_q) begin
            next_state = S_DONE;
          end else if (dmem_rvalid) begin
            load_cpl   = 1'b1;
            next_state = S_DONE;
          end else begin
            next_state = S_WAIT_R;
          end
        end else if (timed_out) begin
          stall_c    = 1'b0;
          fault_c    = 1'b1;
          next_state = S_IDLE;
        end
      end

      S_WAIT_R: begin
        stall_c = 1'b1;
        if (dmem_rvalid) begin
          load_cpl   = 1'b1;
          next_state = S_DONE;
        end else if (timed_out) begin
          stall_c    = 1'b0;
          fault_c    = 1'b1;
          next_state = S_IDLE;
        end
      end

      S_DONE: begin
        done_c     = 1'b1;
        next_state = S_IDLE;
      end

      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= 32'h0;
      is_load_q <= 1'b0;
      load_q    <= 3'b000;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      timer_q   <= 8'h00;
    end else begin
      if (accept) begin
        addr_q    <= Addr;
        is_load_q <= MemRead;
        load_q    <= Load;
        be_q      <= MemRead ? 4'b0000 : be_c;
        wdata_q   <= MemRead ? 32'h0 : wdata_c;
      end
      if (accept) begin
        timer_q <= 8'h00;
      end else if (state == S_REQ || state == S_WAIT_R) begin
        timer_q <= timer_q + 8'd1;
      end
      if (load_cpl) rdata_q <= rdata_ext;
    end
  end

  // IDLE-cycle outputs depend on core inputs, so they are masked during reset.
  assign Stall         = stall_c & ~reset;
  assign MisalignFault = fault_c & ~reset;
  assign Done          = done_c;
  assign dmem_req      = req_c;
  assign dmem_we       = we_c;
  assign dmem_addr     = {addr_q[31:2], 2'b00};
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign RData         = rdata_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: table of single transfers with
// hand-computed results plus hand-written timeout and reset sequences.
module tb_lsu_controller;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Load;
  logic [1:0]  Store;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic        Stall;
  logic        Done;
  logic [31:0] RData;
  logic        MisalignFault;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [1:0]  fsm_state;

  lsu_controller dut (
    .clk           (clk),
    .reset         (reset),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .Load          (Load),
    .Store         (Store),
    .Addr          (Addr),
    .WData         (WData),
    .Stall         (Stall),
    .Done          (Done),
    .RData         (RData),
    .MisalignFault (MisalignFault),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ready    (dmem_ready),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rw;
    int          vw;
    logic        flt;
    logic [3:0]  be;
    logic [31:0] wexp;
    logic [31:0] rexp;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  int           cur_vec = -1;
  logic [31:0]  exp_q[$];
  vec_t         vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %h want %h", cur_vec, name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] ld,
                              input logic [1:0] st, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int rw, input int vw, input logic flt,
                              input logic [3:0] be, input logic [31:0] wexp,
                              input logic [31:0] rexp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.rw = rw; v.vw = vw; v.flt = flt; v.be = be;
    v.wexp = wexp; v.rexp = rexp;
    return v;
  endfunction

  // driver: entered just after a rising edge with the DUT idle, leaves likewise
  task automatic run_vec(input vec_t v);
    int          n_busy;
    int          stall_n;
    int          early_done;
    logic [31:0] rexp;
    MemRead = v.rd; MemWrite = v.wr; Load = v.ld; Store = v.st;
    Addr = v.addr; WData = v.wdata;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = v.rdata;
    exp_q.push_back(v.rexp);
    @(negedge clk);
    if (v.flt) begin
      check("flt_pulse", 32'(MisalignFault), 32'd1);
      check("flt_stall", 32'(Stall), 32'd0);
      check("flt_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      @(negedge clk);
      rexp = exp_q.pop_front();
      check("flt_once", 32'(MisalignFault), 32'd0);
      check("flt_idle", 32'(fsm_state), 32'd0);
      check("flt_req2", 32'(dmem_req), 32'd0);
      check("flt_rdata", RData, rexp);
      @(posedge clk); #1;
      return;
    end
    check("acc_stall", 32'(Stall), 32'd1);
    check("acc_fault", 32'(MisalignFault), 32'd0);
    stall_n    = Stall ? 1 : 0;
    early_done = 0;
    n_busy     = v.rw + 1 + (v.rd ? v.vw : 0);
    for (int c = 0; c < n_busy; c++) begin
      @(posedge clk); #1;
      dmem_ready  = (c == v.rw);
      dmem_rvalid = v.rd && (c == n_busy - 1);
      @(negedge clk);
      if (c == 0) begin
        check("req", 32'(dmem_req), 32'd1);
        check("we", 32'(dmem_we), 32'(v.wr));
        check("addr", dmem_addr, {v.addr[31:2], 2'b00});
        check("be", 32'(dmem_be), 32'(v.be));
        if (v.wr) check("wdata", dmem_wdata, v.wexp);
      end
      if (Stall) stall_n++;
      if (Done) early_done++;
    end
    @(posedge clk); #1;
    dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    rexp = exp_q.pop_front();
    check("done", 32'(Done), 32'd1);
    check("done_stall", 32'(Stall), 32'd0);
    check("done_req", 32'(dmem_req), 32'd0);
    check("rdata", RData, rexp);
    check("stall_cycles", 32'(stall_n), 32'(n_busy + 1));
    check("early_done", 32'(early_done), 32'd0);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check("done_once", 32'(Done), 32'd0);
    check("back_idle", 32'(fsm_state), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int          fault_at;
    int          stall_n;
    int          done_seen;

    vecs[0]  = mk(1, 0, 3'b010, 2'b00, 32'h100, 32'h0, 32'hDEADBEEF, 2, 1, 0, 4'b0000, 32'h0, 32'hDEADBEEF);
    vecs[1]  = mk(1, 0, 3'b000, 2'b00, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 0, 4'b0000, 32'h0, 32'hFFFFFF80);
    vecs[2]  = mk(1, 0, 3'b011, 2'b00, 32'h103, 32'h0, 32'h80FF1234, 1, 0, 0, 4'b0000, 32'h0, 32'h00000080);
    vecs[3]  = mk(1, 0, 3'b101, 2'b00, 32'h102, 32'h0, 32'h80FF1234, 0, 2, 0, 4'b0000, 32'h0, 32'h000080FF);
    vecs[4]  = mk(1, 0, 3'b001, 2'b00, 32'h102, 32'h0, 32'h80FF1234, 0, 0, 0, 4'b0000, 32'h0, 32'hFFFF80FF);
    vecs[5]  = mk(1, 0, 3'b001, 2'b00, 32'h100, 32'h0, 32'h80FF1234, 1, 1, 0, 4'b0000, 32'h0, 32'h00001234);
    vecs[6]  = mk(1, 0, 3'b000, 2'b00, 32'h101, 32'h0, 32'h80FF1234, 0, 0, 0, 4'b0000, 32'h0, 32'h00000012);
    vecs[7]  = mk(0, 1, 3'b000, 2'b01, 32'h206, 32'h0000ABCD, 32'h0, 0, 0, 0, 4'b1100, 32'hABCDABCD, 32'h00000012);
    vecs[8]  = mk(0, 1, 3'b000, 2'b00, 32'h301, 32'h12345678, 32'h0, 2, 0, 0, 4'b0010, 32'h78787878, 32'h00000012);
    vecs[9]  = mk(0, 1, 3'b000, 2'b10, 32'h400, 32'hCAFEF00D, 32'h0, 1, 0, 0, 4'b1111, 32'hCAFEF00D, 32'h00000012);
    vecs[10] = mk(1, 0, 3'b010, 2'b00, 32'h101, 32'h0, 32'h11111111, 0, 0, 1, 4'b0000, 32'h0, 32'h00000012);
    vecs[11] = mk(1, 0, 3'b110, 2'b00, 32'h100, 32'h0, 32'h11111111, 0, 0, 1, 4'b0000, 32'h0, 32'h00000012);
    vecs[12] = mk(0, 1, 3'b000, 2'b01, 32'h203, 32'h5555, 32'h0, 0, 0, 1, 4'b0000, 32'h0, 32'h00000012);
    vecs[13] = mk(0, 1, 3'b000, 2'b11, 32'h400, 32'h5555, 32'h0, 0, 0, 1, 4'b0000, 32'h0, 32'h00000012);
    vecs[14] = mk(1, 1, 3'b010, 2'b10, 32'h100, 32'h5555, 32'h0, 0, 0, 1, 4'b0000, 32'h0, 32'h00000012);
    vecs[15] = mk(1, 0, 3'b101, 2'b00, 32'h101, 32'h0, 32'h0, 0, 0, 1, 4'b0000, 32'h0, 32'h00000012);
    vecs[16] = mk(0, 1, 3'b000, 2'b10, 32'h402, 32'h5555, 32'h0, 0, 0, 1, 4'b0000, 32'h0, 32'h00000012);
    vecs[17] = mk(1, 0, 3'b010, 2'b00, 32'h500, 32'h0, 32'h01234567, 0, 0, 0, 4'b0000, 32'h0, 32'h01234567);
    vecs[18] = mk(0, 1, 3'b000, 2'b00, 32'h003, 32'h000000A5, 32'h0, 0, 0, 0, 4'b1000, 32'hA5A5A5A5, 32'h01234567);

    // reset state, with a legal load presented so stall masking is visible
    reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Load = 3'b010; Store = 2'b00;
    Addr = 32'h100; WData = 32'h0; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_fault", 32'(MisalignFault), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_rdata", RData, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0;

    for (int i = 0; i < 19; i++) begin
      cur_vec = i;
      run_vec(vecs[i]);
    end

    // timeout: memory never answers
    cur_vec = 100;
    MemRead = 1'b1; Load = 3'b010; Addr = 32'h600; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);
    check("to_acc_stall", 32'(Stall), 32'd1);
    fault_at = -1; stall_n = 0; done_seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (Done) done_seen++;
      if (MisalignFault) begin
        fault_at = c;
        check("to_stall_drop", 32'(Stall), 32'd0);
        break;
      end
      if (Stall) stall_n++;
    end
    check("to_cycle", 32'(fault_at), 32'd255);
    check("to_stall_cycles", 32'(stall_n), 32'd255);
    check("to_no_done", 32'(done_seen), 32'd0);
    @(posedge clk); #1;
    MemRead = 1'b0;
    @(negedge clk);
    check("to_idle", 32'(fsm_state), 32'd0);
    check("to_req", 32'(dmem_req), 32'd0);
    check("to_fault_once", 32'(MisalignFault), 32'd0);
    check("to_rdata", RData, 32'h01234567);
    @(posedge clk); #1;

    // reset while the request is outstanding in REQ
    cur_vec = 101;
    MemRead = 1'b1; Load = 3'b010; Addr = 32'h700;
    @(posedge clk); #1;
    @(negedge clk);
    check("rq_req", 32'(dmem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rq_rst_req", 32'(dmem_req), 32'd0);
    check("rq_rst_stall", 32'(Stall), 32'd0);
    check("rq_rst_state", 32'(fsm_state), 32'd0);
    check("rq_rst_addr", dmem_addr, 32'h0);
    check("rq_rst_rdata", RData, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0;
    @(posedge clk); #1;

    // reset while waiting for read data in WAIT_R
    cur_vec = 102;
    MemRead = 1'b1; Load = 3'b010; Addr = 32'h704;
    @(posedge clk); #1;
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    @(negedge clk);
    check("wr_state", 32'(fsm_state), 32'd2);
    check("wr_stall", 32'(Stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("wr_rst_req", 32'(dmem_req), 32'd0);
    check("wr_rst_stall", 32'(Stall), 32'd0);
    check("wr_rst_state", 32'(fsm_state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; MemRead = 1'b0;

    // recovery after reset: zero-wait load
    cur_vec = 103;
    run_vec(mk(1, 0, 3'b010, 2'b00, 32'h708, 32'h0, 32'h0BADF00D, 0, 0, 0, 4'b0000, 32'h0, 32'h0BADF00D));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_controller.md
LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 MemRead  input  1  load instruction in execute; held by core while Stall=1.
REQ-004 MemWrite  input  1  store instruction in execute; held by core while Stall=1.
REQ-005 Load  input  3  load type: 000 lb, 001 lh, 010 lw, 011 lbu, 101 lhu; other codes illegal.
REQ-006 Store  input  2  store type: 00 sb, 01 sh, 10 sw; 11 illegal.
REQ-007 Addr  input  32  byte address from ALU.
REQ-008 WData  input  32  store source register value.
REQ-009 Stall  output  1  freezes PC and pipeline while a transfer is outstanding.
REQ-010 Done  output  1  one-cycle pulse; transfer complete, RData valid.
REQ-011 RData  output  32  extended load result, held until next load completes.
REQ-012 MisalignFault  output  1  one-cycle pulse on misaligned, illegal-code or timed-out access.
REQ-013 dmem_req / dmem_we  output  1 / 1  memory request; write when dmem_we=1.
REQ-014 dmem_addr / dmem_be / dmem_wdata  output  32 / 4 / 32  word address ({Addr[31:2],2'b00}), byte enables, lane-replicated write data.
REQ-015 dmem_ready / dmem_rvalid / dmem_rdata  input  1 / 1 / 32  request accepted; read data valid; read data.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT_R, DONE.
REQ-017 IDLE: MemRead or MemWrite with legal code and aligned Addr SHALL latch Addr, type, WData; assert Stall combinationally the same cycle; go to REQ.
REQ-018 Alignment: lh/lhu/sh need Addr[0]=0; lw/sw need Addr[1:0]=00; byte ops are always aligned.
REQ-019 Misaligned, illegal code, or MemRead and MemWrite both high SHALL pulse MisalignFault in that IDLE cycle, issue no request, keep Stall=0, stay IDLE.
REQ-020 REQ: dmem_req=1, dmem_addr/be/wdata/we stable until dmem_ready=1; store on ready -> DONE; load on ready -> WAIT_R, or DONE directly if dmem_rvalid=1 in the same cycle.
REQ-021 WAIT_R: on dmem_rvalid latch extracted data into RData -> DONE.
REQ-022 DONE: Done=1, Stall=0 for exactly one cycle; next state IDLE. No new request is accepted in DONE, so the core must advance past the instruction.
REQ-023 Byte enables: sb 4'b0001<<Addr[1:0]; sh 4'b0011<<{Addr[1],1'b0}; sw 4'b1111; dmem_be=0 for loads.
REQ-024 Write data: sb {4{WData[7:0]}}; sh {2{WData[15:0]}}; sw WData.
REQ-025 Load extraction: lane chosen by Addr[1:0]; lb/lh sign-extend; lbu/lhu zero-extend; lw pass-through.
REQ-026 8-bit timeout counter SHALL clear on entering REQ, increment each cycle in REQ or WAIT_R, and at 255 pulse MisalignFault, drop Stall, and return to IDLE with no Done.
REQ-027 Minimum latency: zero-wait memory (ready and rvalid on first REQ cycle) gives Stall for 2 cycles (IDLE, REQ) and Done in the third.

Reset
REQ-028 reset SHALL force IDLE and zero every output, RData, latched fields and counter, asynchronously and immediately, including mid-transfer: dmem_req drops without waiting for dmem_ready.
REQ-029 First request SHALL be accepted on the first clk edge after reset deasserts.

Structure
REQ-030 Shared package lsu_pkg SHALL hold Load/Store code constants, the state enum and the TIMEOUT constant (255).
REQ-031 One combinational sub-module lsu_align SHALL compute alignment check, byte enables, write replication and load extension.

Verification
REQ-032 lw Addr=0x100, mem returns 0xDEADBEEF after 3 cycles -> dmem_addr=0x100, be=0000, RData=0xDEADBEEF, single Done pulse, Stall low in DONE.
REQ-033 lb Addr=0x103, rdata=0x80FF1234 -> RData=0xFFFFFF80; lbu same -> 0x00000080; lhu Addr=0x102 -> 0x000080FF.
REQ-034 sh Addr=0x206 WData=0x0000ABCD, zero-wait -> be=1100, wdata=0xABCDABCD, Done in third cycle.
REQ-035 lw Addr=0x101 -> MisalignFault pulse, dmem_req never high, Stall=0; Load=110 -> same.
REQ-036 dmem_ready held low 255 cycles -> MisalignFault pulse, return to IDLE; reset asserted during WAIT_R -> dmem_req=0, Stall=0 immediately.
